// File: rtl/peripheral_opseq_pkg.sv
// Shared types and constants for the calculator operand/result sequencer.
// The state encoding is visible on the LEDs through state_o.
package peripheral_opseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SHOW   = 3'd5,
    ST_ERR    = 3'd6
  } opseq_state_t;

  localparam int         NBYTES_DEF = 4;
  localparam logic [7:0] ERR_CODE   = 8'hEE;

endpackage

// File: rtl/peripheral_edge_detect.sv
// Turns a synchronised key level into a single-cycle registered pulse on its rising edge.
// Holding the key therefore yields exactly one pulse.
module peripheral_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_r;
  logic pulse_r;

  // Remember the previous level and flag a 0->1 transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      prev_r  <= level;
      pulse_r <= level & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/peripheral_opsequencer.sv
// Operand/result sequencer: gathers A and B bytes from the switches, launches the ALU,
// waits for done with a timeout and steps the result bytes onto the display.
module peripheral_opsequencer
  import peripheral_opseq_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enterpulse,
  input  logic                loaddata,
  input  logic [7:0]          inputdata,
  input  logic                alu_done,
  input  logic [NBYTES*8-1:0] dataR,
  output logic                alu_start,
  output logic [NBYTES*8-1:0] dataA,
  output logic [NBYTES*8-1:0] dataB,
  output logic [7:0]          dataoutput,
  output logic [3:0]          pos,
  output logic [2:0]          state_o,
  output logic                busy,
  output logic                error
);

  localparam int         W    = NBYTES * 8;
  localparam int         TW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST = 4'(NBYTES - 1);

  opseq_state_t  state_r;
  logic [W-1:0]  data_a_r;
  logic [W-1:0]  data_b_r;
  logic [W-1:0]  result_r;
  logic [7:0]    dout_r;
  logic [3:0]    pos_r;
  logic [TW-1:0] timer_r;
  logic          start_r;
  logic          busy_r;
  logic          error_r;
  logic          ep_s;
  logic [3:0]    next_pos_s;
  logic [7:0]    show_byte_s;

  peripheral_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (enterpulse),
    .pulse (ep_s)
  );

  // Next display index (wrapping) and the result byte it selects
  always_comb begin
    next_pos_s  = 4'd0;
    show_byte_s = 8'd0;
    if (pos_r == LAST) begin
      next_pos_s = 4'd0;
    end else begin
      next_pos_s = pos_r + 4'd1;
    end
    show_byte_s = result_r[next_pos_s*8 +: 8];
  end

  // Sequencer FSM with operand byte writes and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      data_a_r <= {W{1'b0}};
      data_b_r <= {W{1'b0}};
      result_r <= {W{1'b0}};
      dout_r   <= 8'd0;
      pos_r    <= 4'd0;
      timer_r  <= {TW{1'b0}};
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ep_s && loaddata) begin
            data_a_r[7:0] <= inputdata;
            dout_r        <= inputdata;
            pos_r         <= 4'd1;
            state_r       <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (ep_s && loaddata) begin
            data_a_r[pos_r*8 +: 8] <= inputdata;
            dout_r                 <= inputdata;
            if (pos_r == LAST) begin
              pos_r   <= 4'd0;
              state_r <= ST_LOAD_B;
            end else begin
              pos_r <= pos_r + 4'd1;
            end
          end
        end
        ST_LOAD_B: begin
          if (ep_s && loaddata) begin
            data_b_r[pos_r*8 +: 8] <= inputdata;
            dout_r                 <= inputdata;
            if (pos_r == LAST) begin
              pos_r   <= 4'd0;
              start_r <= 1'b1;
              busy_r  <= 1'b1;
              state_r <= ST_START;
            end else begin
              pos_r <= pos_r + 4'd1;
            end
          end
        end
        ST_START: begin
          timer_r <= {TW{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the timeout cycle still takes precedence
          if (alu_done) begin
            result_r <= dataR;
            pos_r    <= 4'd0;
            dout_r   <= dataR[7:0];
            busy_r   <= 1'b0;
            state_r  <= ST_SHOW;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            timer_r <= timer_r + TW'(1);
            dout_r  <= ERR_CODE;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
            state_r <= ST_ERR;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_SHOW: begin
          if (ep_s) begin
            if (loaddata) begin
              data_a_r <= {{(W-8){1'b0}}, inputdata};
              data_b_r <= {W{1'b0}};
              dout_r   <= inputdata;
              pos_r    <= 4'd1;
              state_r  <= ST_LOAD_A;
            end else begin
              pos_r  <= next_pos_s;
              dout_r <= show_byte_s;
            end
          end
        end
        ST_ERR: begin
          if (ep_s) begin
            data_a_r <= {W{1'b0}};
            data_b_r <= {W{1'b0}};
            pos_r    <= 4'd0;
            dout_r   <= 8'd0;
            error_r  <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          error_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_start  = start_r;
  assign dataA      = data_a_r;
  assign dataB      = data_b_r;
  assign dataoutput = dout_r;
  assign pos        = pos_r;
  assign state_o    = state_r;
  assign busy       = busy_r;
  assign error      = error_r;

endmodule

// File: tb/tb_peripheral_opsequencer.sv
// Directed self-checking bench for peripheral_opsequencer (NBYTES=4, TIMEOUT=255).
module tb_peripheral_opsequencer;

  logic        clk;
  logic        reset;
  logic        enterpulse;
  logic        loaddata;
  logic [7:0]  inputdata;
  logic        alu_done;
  logic [31:0] dataR;
  logic        alu_start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [7:0]  dataoutput;
  logic [3:0]  pos;
  logic [2:0]  state_o;
  logic        busy;
  logic        error;

  int passed = 0;
  int total  = 0;

  peripheral_opsequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enterpulse (enterpulse),
    .loaddata   (loaddata),
    .inputdata  (inputdata),
    .alu_done   (alu_done),
    .dataR      (dataR),
    .alu_start  (alu_start),
    .dataA      (dataA),
    .dataB      (dataB),
    .dataoutput (dataoutput),
    .pos        (pos),
    .state_o    (state_o),
    .busy       (busy),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One press: returns at the negedge right after the FSM has acted on it
  task automatic press(input logic ld, input logic [7:0] d);
    @(negedge clk);
    loaddata   = ld;
    inputdata  = d;
    enterpulse = 1'b1;
    @(negedge clk);
    enterpulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_ab(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) press(1'b1, a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) press(1'b1, b[i*8 +: 8]);
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({state_o, alu_start, busy, error, pos, dataoutput, dataA, dataB} !== 83'd0)
      $display("FAIL reset_state: state=%0d start=%b busy=%b err=%b pos=%0d dout=%h A=%h B=%h required all zero",
               state_o, alu_start, busy, error, pos, dataoutput, dataA, dataB);
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_and_start;
    press(1'b1, 8'h11);
    total++;
    if (state_o !== 3'd1 || pos !== 4'd1 || dataoutput !== 8'h11)
      $display("FAIL first_byte: state=%0d pos=%0d dout=%h required 1/1/11", state_o, pos, dataoutput);
    else passed++;
    press(1'b1, 8'h22);
    press(1'b1, 8'h33);
    press(1'b1, 8'h44);
    total++;
    if (dataA !== 32'h44332211 || state_o !== 3'd2 || pos !== 4'd0)
      $display("FAIL load_a: A=%h state=%0d pos=%0d required 44332211/2/0", dataA, state_o, pos);
    else passed++;
    press(1'b1, 8'h01);
    press(1'b1, 8'h00);
    press(1'b1, 8'h00);
    // eighth press, watched cycle by cycle
    @(negedge clk);
    inputdata  = 8'h00;
    enterpulse = 1'b1;
    @(negedge clk);
    total++;
    if (alu_start !== 1'b0)
      $display("FAIL start_early: alu_start=%b required 0 on ep cycle", alu_start);
    else passed++;
    enterpulse = 1'b0;
    @(negedge clk);
    total++;
    if (alu_start !== 1'b1 || state_o !== 3'd3 || busy !== 1'b1 || dataB !== 32'h00000001)
      $display("FAIL start_pulse: start=%b state=%0d busy=%b B=%h required 1/3/1/00000001",
               alu_start, state_o, busy, dataB);
    else passed++;
    @(negedge clk);
    total++;
    if (alu_start !== 1'b0 || state_o !== 3'd4 || busy !== 1'b1)
      $display("FAIL start_width: start=%b state=%0d busy=%b required 0/4/1", alu_start, state_o, busy);
    else passed++;
    repeat (3) @(negedge clk);
    alu_done = 1'b1;
    dataR    = 32'hDEADBEEF;
    @(negedge clk);
    alu_done = 1'b0;
    total++;
    if (state_o !== 3'd5 || pos !== 4'd0 || dataoutput !== 8'hEF || busy !== 1'b0 || dataA !== 32'h44332211)
      $display("FAIL show_entry: state=%0d pos=%0d dout=%h busy=%b A=%h required 5/0/EF/0/44332211",
               state_o, pos, dataoutput, busy, dataA);
    else passed++;
  endtask

  task automatic test_show_steps;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hBE; exp_b[1] = 8'hAD; exp_b[2] = 8'hDE; exp_b[3] = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 8'h99);
      total++;
      if (dataoutput !== exp_b[i] || pos !== 4'((i + 1) % 4) || state_o !== 3'd5)
        $display("FAIL show_step%0d: dout=%h pos=%0d state=%0d required %h/%0d/5",
                 i, dataoutput, pos, state_o, exp_b[i], (i + 1) % 4);
      else passed++;
    end
  endtask

  task automatic test_reload_from_show;
    press(1'b1, 8'h7F);
    total++;
    if (dataA !== 32'h0000007F || dataB !== 32'd0 || state_o !== 3'd1 || pos !== 4'd1)
      $display("FAIL reload: A=%h B=%h state=%0d pos=%0d required 0000007F/0/1/1", dataA, dataB, state_o, pos);
    else passed++;
  endtask

  task automatic test_hold_and_ignore;
    @(negedge clk);
    loaddata   = 1'b1;
    inputdata  = 8'h55;
    enterpulse = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (pos !== 4'd2 || dataA !== 32'h0000557F)
      $display("FAIL hold_key: pos=%0d A=%h required 2/0000557F", pos, dataA);
    else passed++;
    enterpulse = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b0, 8'hAA);
    total++;
    if (pos !== 4'd2 || dataA !== 32'h0000557F || dataoutput !== 8'h55 || state_o !== 3'd1)
      $display("FAIL ignore_step: pos=%0d A=%h dout=%h state=%0d required 2/0000557F/55/1",
               pos, dataA, dataoutput, state_o);
    else passed++;
  endtask

  task automatic test_timeout;
    press(1'b1, 8'h66);
    press(1'b1, 8'h77);
    for (int i = 1; i <= 4; i++) press(1'b1, 8'(i));
    total++;
    if (state_o !== 3'd3 || dataA !== 32'h7766557F || dataB !== 32'h04030201)
      $display("FAIL operands: state=%0d A=%h B=%h required 3/7766557F/04030201", state_o, dataA, dataB);
    else passed++;
    @(negedge clk);
    repeat (254) @(negedge clk);
    total++;
    if (state_o !== 3'd4 || error !== 1'b0)
      $display("FAIL before_timeout: state=%0d error=%b required 4/0", state_o, error);
    else passed++;
    @(negedge clk);
    total++;
    if (state_o !== 3'd6 || error !== 1'b1 || dataoutput !== 8'hEE || busy !== 1'b0)
      $display("FAIL timeout: state=%0d error=%b dout=%h busy=%b required 6/1/EE/0",
               state_o, error, dataoutput, busy);
    else passed++;
    press(1'b0, 8'h00);
    total++;
    if (state_o !== 3'd0 || error !== 1'b0 || dataA !== 32'd0 || dataB !== 32'd0 || pos !== 4'd0)
      $display("FAIL err_exit: state=%0d error=%b A=%h B=%h pos=%0d required 0/0/0/0/0",
               state_o, error, dataA, dataB, pos);
    else passed++;
  endtask

  task automatic test_done_wins;
    enter_ab(32'hA1B2C3D4, 32'h00000002);
    @(negedge clk);
    repeat (254) @(negedge clk);
    alu_done = 1'b1;
    dataR    = 32'h12345678;
    @(negedge clk);
    alu_done = 1'b0;
    total++;
    if (state_o !== 3'd5 || error !== 1'b0 || dataoutput !== 8'h78)
      $display("FAIL done_wins: state=%0d error=%b dout=%h required 5/0/78", state_o, error, dataoutput);
    else passed++;
  endtask

  task automatic test_reset_in_wait;
    logic bad;
    enter_ab(32'h04030201, 32'h08070605);
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({state_o, alu_start, busy, error, pos, dataoutput, dataA, dataB} !== 83'd0)
      $display("FAIL reset_in_wait: state=%0d start=%b busy=%b err=%b pos=%0d dout=%h A=%h B=%h required all zero",
               state_o, alu_start, busy, error, pos, dataoutput, dataA, dataB);
    else passed++;
    @(negedge clk);
    reset    = 1'b1;
    alu_done = 1'b1;
    dataR    = 32'hFFFFFFFF;
    bad      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alu_start !== 1'b0 || state_o !== 3'd0 || dataoutput !== 8'd0) bad = 1'b1;
    end
    alu_done = 1'b0;
    total++;
    if (bad !== 1'b0)
      $display("FAIL done_after_reset: state=%0d start=%b dout=%h required 0/0/00", state_o, alu_start, dataoutput);
    else passed++;
  endtask

  initial begin
    reset      = 1'b0;
    enterpulse = 1'b0;
    loaddata   = 1'b0;
    inputdata  = 8'h00;
    alu_done   = 1'b0;
    dataR      = 32'h0;
    test_reset;
    test_load_and_start;
    test_show_steps;
    test_reload_from_show;
    test_hold_and_ignore;
    test_timeout;
    test_done_wins;
    test_reset_in_wait;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
